// File: rtl/riscv_multi_cycle.sv
// Multi-cycle RV32I-subset core: one FSM walks FETCH/DECODE/EXEC/MEM/WB over a shared
// req/ready memory port; illegal or misaligned work parks the core in a sticky HALT.
module riscv_multi_cycle #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          NUM_REGS        = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic [31:0] pc_out,
  output logic        halted
);
  localparam int         RW   = $clog2(NUM_REGS);
  localparam logic [5:0] NREG = 6'(NUM_REGS);

  typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {C_NOP, C_ALU, C_LUI, C_LW, C_SW, C_BR, C_JAL, C_JALR} class_e;
  typedef enum logic [3:0] {A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLT, A_SLL, A_SRL, A_SRA} aluop_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] imm_q, imm_d, y_q, y_d, mdr_q, mdr_d;
  logic        nop_q, nop_d;
  logic [31:0] rf_q [NUM_REGS];

  logic [6:0]  opc_s, f7_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  f3_s;
  class_e      cls_s;
  aluop_e      op_s;
  logic        use_imm_s, op_ok_s, use_rs1_s, use_rs2_s, use_rd_s, legal_s;
  logic [31:0] imm_s, rs1_val_s, rs2_val_s, alu_a_s, alu_b_s, alu_s;
  logic [31:0] pc_plus4_s, br_tgt_s, jalr_tgt_s, rf_wdata_s;
  logic        taken_s, rf_we_s;

  assign opc_s = ir_q[6:0];
  assign rd_s  = ir_q[11:7];
  assign f3_s  = ir_q[14:12];
  assign rs1_s = ir_q[19:15];
  assign rs2_s = ir_q[24:20];
  assign f7_s  = ir_q[31:25];

  // Instruction decode: class, ALU op, immediate format and legality
  always_comb begin
    cls_s     = C_NOP;
    op_s      = A_ADD;
    use_imm_s = 1'b1;
    op_ok_s   = 1'b1;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    use_rd_s  = 1'b0;
    imm_s     = {{20{ir_q[31]}}, ir_q[31:20]};
    case (opc_s)
      7'b0110011: begin
        cls_s = C_ALU; use_imm_s = 1'b0; use_rs1_s = 1'b1; use_rs2_s = 1'b1; use_rd_s = 1'b1;
        case ({f7_s, f3_s})
          {7'h00, 3'b000}: op_s = A_ADD;
          {7'h20, 3'b000}: op_s = A_SUB;
          {7'h00, 3'b111}: op_s = A_AND;
          {7'h00, 3'b110}: op_s = A_OR;
          {7'h00, 3'b100}: op_s = A_XOR;
          {7'h00, 3'b010}: op_s = A_SLT;
          {7'h00, 3'b001}: op_s = A_SLL;
          {7'h00, 3'b101}: op_s = A_SRL;
          {7'h20, 3'b101}: op_s = A_SRA;
          default:         op_ok_s = 1'b0;
        endcase
      end
      7'b0010011: begin
        cls_s = C_ALU; use_rs1_s = 1'b1; use_rd_s = 1'b1;
        case (f3_s)
          3'b000:  op_s = A_ADD;
          3'b111:  op_s = A_AND;
          3'b110:  op_s = A_OR;
          3'b100:  op_s = A_XOR;
          3'b010:  op_s = A_SLT;
          3'b001:  begin op_s = A_SLL; op_ok_s = (f7_s == 7'h00); end
          3'b101:  begin op_s = (f7_s == 7'h20) ? A_SRA : A_SRL;
                         op_ok_s = (f7_s == 7'h00) || (f7_s == 7'h20); end
          default: op_ok_s = 1'b0;
        endcase
      end
      7'b0110111: begin cls_s = C_LUI; use_rd_s = 1'b1; imm_s = {ir_q[31:12], 12'h000}; end
      7'b0000011: begin cls_s = C_LW; use_rs1_s = 1'b1; use_rd_s = 1'b1; op_ok_s = (f3_s == 3'b010); end
      7'b0100011: begin
        cls_s = C_SW; use_rs1_s = 1'b1; use_rs2_s = 1'b1; op_ok_s = (f3_s == 3'b010);
        imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      end
      7'b1100011: begin
        cls_s = C_BR; use_rs1_s = 1'b1; use_rs2_s = 1'b1; op_ok_s = (f3_s[2:1] == 2'b00);
        imm_s = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      end
      7'b1101111: begin
        cls_s = C_JAL; use_rd_s = 1'b1;
        imm_s = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      end
      7'b1100111: begin cls_s = C_JALR; use_rs1_s = 1'b1; use_rd_s = 1'b1; op_ok_s = (f3_s == 3'b000); end
      default:    op_ok_s = 1'b0;
    endcase
  end

  // A register field beyond NUM_REGS makes the instruction illegal even if the opcode is fine
  assign legal_s = op_ok_s
                && !(use_rs1_s && ({1'b0, rs1_s} >= NREG))
                && !(use_rs2_s && ({1'b0, rs2_s} >= NREG))
                && !(use_rd_s  && ({1'b0, rd_s}  >= NREG));

  assign rs1_val_s = (rs1_s == 5'd0) ? 32'h0 : rf_q[rs1_s[RW-1:0]];
  assign rs2_val_s = (rs2_s == 5'd0) ? 32'h0 : rf_q[rs2_s[RW-1:0]];

  assign alu_a_s = (cls_s == C_LUI) ? 32'h0 : a_q;
  assign alu_b_s = use_imm_s ? imm_q : b_q;

  // ALU
  always_comb begin
    alu_s = 32'h0;
    case (op_s)
      A_ADD:   alu_s = alu_a_s + alu_b_s;
      A_SUB:   alu_s = alu_a_s - alu_b_s;
      A_AND:   alu_s = alu_a_s & alu_b_s;
      A_OR:    alu_s = alu_a_s | alu_b_s;
      A_XOR:   alu_s = alu_a_s ^ alu_b_s;
      A_SLT:   alu_s = {31'h0, $signed(alu_a_s) < $signed(alu_b_s)};
      A_SLL:   alu_s = alu_a_s << alu_b_s[4:0];
      A_SRL:   alu_s = alu_a_s >> alu_b_s[4:0];
      A_SRA:   alu_s = $signed(alu_a_s) >>> alu_b_s[4:0];
      default: alu_s = alu_a_s + alu_b_s;
    endcase
  end

  assign pc_plus4_s = pc_q + 32'd4;
  assign br_tgt_s   = pc_q + imm_q;
  assign jalr_tgt_s = (a_q + imm_q) & ~32'h1;
  assign taken_s    = (f3_s[0] == 1'b0) ? (a_q == b_q) : (a_q != b_q);

  // Next-state and control; misalignment is caught in EXEC so nothing has been touched yet
  always_comb begin
    state_d = state_q; pc_d = pc_q; ir_d = ir_q; a_d = a_q; b_d = b_q;
    imm_d = imm_q; y_d = y_q; mdr_d = mdr_q; nop_d = nop_q;
    retire = 1'b0; rf_we_s = 1'b0; rf_wdata_s = y_q;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin ir_d = mem_rdata; state_d = S_DECODE; end
        else           begin state_d = S_FETCH; end
      end
      S_DECODE: begin
        a_d = rs1_val_s; b_d = rs2_val_s; imm_d = imm_s; nop_d = 1'b0;
        if (legal_s)              state_d = S_EXEC;
        else if (HALT_ON_ILLEGAL) state_d = S_HALT;
        else begin nop_d = 1'b1; state_d = S_EXEC; end
      end
      S_EXEC: begin
        y_d = alu_s;
        if (nop_q) begin
          pc_d = pc_plus4_s; retire = 1'b1; state_d = S_FETCH;
        end else begin
          case (cls_s)
            C_ALU, C_LUI: state_d = S_WB;
            C_LW, C_SW:   state_d = (alu_s[1:0] != 2'b00) ? S_HALT : S_MEM;
            C_BR: begin
              if (!taken_s)         begin pc_d = pc_plus4_s; retire = 1'b1; state_d = S_FETCH; end
              else if (br_tgt_s[1]) begin state_d = S_HALT; end
              else                  begin pc_d = br_tgt_s; retire = 1'b1; state_d = S_FETCH; end
            end
            C_JAL:   state_d = br_tgt_s[1] ? S_HALT : S_WB;
            C_JALR:  state_d = jalr_tgt_s[1] ? S_HALT : S_WB;
            default: state_d = S_HALT;
          endcase
        end
      end
      S_MEM: begin
        if (!mem_ready)          begin state_d = S_MEM; end
        else if (cls_s == C_LW)  begin mdr_d = mem_rdata; state_d = S_WB; end
        else                     begin pc_d = pc_plus4_s; retire = 1'b1; state_d = S_FETCH; end
      end
      S_WB: begin
        rf_we_s = (rd_s != 5'd0);
        case (cls_s)
          C_LW:          rf_wdata_s = mdr_q;
          C_JAL, C_JALR: rf_wdata_s = pc_plus4_s;
          default:       rf_wdata_s = y_q;
        endcase
        case (cls_s)
          C_JAL:   pc_d = br_tgt_s;
          C_JALR:  pc_d = jalr_tgt_s;
          default: pc_d = pc_plus4_s;
        endcase
        retire = 1'b1; state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Architectural and pipeline-latch state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST; pc_q <= RESET_PC; ir_q <= 32'h0; a_q <= 32'h0; b_q <= 32'h0;
      imm_q <= 32'h0; y_q <= 32'h0; mdr_q <= 32'h0; nop_q <= 1'b0;
    end else begin
      state_q <= state_d; pc_q <= pc_d; ir_q <= ir_d; a_q <= a_d; b_q <= b_d;
      imm_q <= imm_d; y_q <= y_d; mdr_q <= mdr_d; nop_q <= nop_d;
    end
  end

  // Register file
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= 32'h0;
    end else if (rf_we_s) begin
      rf_q[rd_s[RW-1:0]] <= rf_wdata_s;
    end
  end

  assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_we    = (state_q == S_MEM) && (cls_s == C_SW);
  assign mem_addr  = (state_q == S_MEM) ? y_q : pc_q;
  assign mem_wdata = b_q;
  assign pc_out    = pc_q;
  assign halted    = (state_q == S_HALT);
endmodule

// File: tb/tb_riscv_multi_cycle.sv
// Directed bench for riscv_multi_cycle: small programs in a word memory with optional
// fetch wait states; retire spacing, stores, control flow and faults are checked.
module tb_riscv_multi_cycle;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic        n_req, n_we, n_retire, n_halted;
  logic [31:0] n_addr, n_wdata, n_rdata, n_pc;

  logic [31:0] mem [256];
  int          total = 0, bad = 0, cyc = 0;
  int          ret_cnt = 0, st_cnt = 0, fe_cnt = 0, req_done = 0, watch_cnt = 0, n_st_cnt = 0;
  int          ret_cyc [32];
  logic [31:0] st_addr [8], st_data [8], fe_addr [32];
  logic [31:0] n_st_addr = 32'h0, n_st_data = 32'h0;
  logic [31:0] stall_addr = 32'h0, watch_addr = 32'h0;
  int          stall_left = 0;
  bit          ok;

  always #5 clk = ~clk;

  riscv_multi_cycle #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .pc_out(pc_out), .halted(halted));

  riscv_multi_cycle #(.RESET_PC(32'h0000_0000), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst(rst), .mem_req(n_req), .mem_we(n_we), .mem_addr(n_addr),
    .mem_wdata(n_wdata), .mem_rdata(n_rdata), .mem_ready(1'b1),
    .retire(n_retire), .pc_out(n_pc), .halted(n_halted));

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Fetch wait states: the watched fetch address sees ready low and garbage data
  assign mem_ready = !(stall_left > 0 && mem_req && !mem_we && mem_addr == stall_addr);
  assign mem_rdata = mem_ready ? mem[mem_addr[9:2]] : 32'hFFFF_FFFF;

  always_comb begin
    case (n_addr)
      32'h0:   n_rdata = 32'h0000_007F;
      32'h4:   n_rdata = addi(5'd1, 5'd0, 12'd5);
      32'h8:   n_rdata = enc_sw(5'd1, 5'd0, 12'd4);
      32'hC:   n_rdata = enc_b(3'b000, 5'd0, 5'd0, 13'd0);
      default: n_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] <= mem_wdata;
    if (stall_left > 0 && mem_req && !mem_we && mem_addr == stall_addr) stall_left <= stall_left - 1;
  end

  always @(negedge clk) begin
    if (retire) begin
      if (ret_cnt < 32) ret_cyc[ret_cnt] = cyc;
      ret_cnt = ret_cnt + 1;
    end
    if (mem_req && !mem_we && mem_addr == watch_addr) watch_cnt = watch_cnt + 1;
    if (mem_req && mem_ready) begin
      req_done = req_done + 1;
      if (mem_we) begin
        if (st_cnt < 8) begin st_addr[st_cnt] = mem_addr; st_data[st_cnt] = mem_wdata; end
        st_cnt = st_cnt + 1;
      end else begin
        if (fe_cnt < 32) fe_addr[fe_cnt] = mem_addr;
        fe_cnt = fe_cnt + 1;
      end
    end
    if (n_req && n_we) begin
      n_st_addr = n_addr; n_st_data = n_wdata; n_st_cnt = n_st_cnt + 1;
    end
  end

  task automatic begin_test(input logic [31:0] s_addr, input int s_len);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    stall_addr = s_addr; stall_left = s_len; watch_addr = s_addr;
  endtask

  task automatic release_rst();
    @(posedge clk); @(posedge clk); @(negedge clk);
    ret_cnt = 0; st_cnt = 0; fe_cnt = 0; req_done = 0; watch_cnt = 0; n_st_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic wait_halt(output bit done);
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (halted) begin done = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    begin_test(32'h100, 5);
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", mem_req); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
    total++; if (retire !== 1'b0) begin bad++; $display("FAIL rst_retire got=%b exp=0", retire); end
    total++; if (pc_out !== 32'h100) begin bad++; $display("FAIL rst_pc got=%h exp=100", pc_out); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch_req got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL fetch_addr got=%h exp=100", mem_addr); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL fetch_we got=%b exp=0", mem_we); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL abandon_req got=%b exp=0", mem_req); end
  endtask

  task automatic test_alu();
    begin_test(32'hFFFF_FFF0, 0);
    mem[64] = addi(5'd1, 5'd0, 12'd5);
    mem[65] = addi(5'd2, 5'd0, 12'hFFD);
    mem[66] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[67] = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd4);
    mem[68] = enc_sw(5'd3, 5'd0, 12'd64);
    mem[69] = enc_sw(5'd4, 5'd0, 12'd68);
    release_rst();
    wait_halt(ok);
    total++; if (!ok) begin bad++; $display("FAIL alu_halt_timeout got=0 exp=1"); end
    total++; if (ret_cnt !== 6) begin bad++; $display("FAIL alu_retires got=%0d exp=6", ret_cnt); end
    for (int i = 1; i < 4; i++) begin
      total++; if (ret_cyc[i] - ret_cyc[i-1] !== 4) begin bad++; $display("FAIL alu_spacing%0d got=%0d exp=4", i, ret_cyc[i] - ret_cyc[i-1]); end
    end
    total++; if (mem[16] !== 32'h2) begin bad++; $display("FAIL alu_x3 got=%h exp=2", mem[16]); end
    total++; if (mem[17] !== 32'hFFFF_FFF8) begin bad++; $display("FAIL alu_x4 got=%h exp=fffffff8", mem[17]); end
    total++; if (pc_out !== 32'h118) begin bad++; $display("FAIL alu_halt_pc got=%h exp=118", pc_out); end
  endtask

  task automatic test_wait();
    begin_test(32'h104, 3);
    mem[64] = addi(5'd1, 5'd0, 12'd7);
    mem[65] = addi(5'd2, 5'd0, 12'd9);
    mem[66] = enc_sw(5'd2, 5'd0, 12'd64);
    release_rst();
    wait_halt(ok);
    total++; if (!ok) begin bad++; $display("FAIL wait_halt_timeout got=0 exp=1"); end
    total++; if (watch_cnt !== 4) begin bad++; $display("FAIL wait_addr_cycles got=%0d exp=4", watch_cnt); end
    total++; if (ret_cyc[1] - ret_cyc[0] !== 7) begin bad++; $display("FAIL wait_latency got=%0d exp=7", ret_cyc[1] - ret_cyc[0]); end
    total++; if (ret_cnt !== 3) begin bad++; $display("FAIL wait_retires got=%0d exp=3", ret_cnt); end
    total++; if (mem[16] !== 32'h9) begin bad++; $display("FAIL wait_x2 got=%h exp=9", mem[16]); end
  endtask

  task automatic test_mem();
    begin_test(32'hFFFF_FFF0, 0);
    mem[64] = addi(5'd3, 5'd0, 12'd2);
    mem[65] = enc_sw(5'd3, 5'd0, 12'd8);
    mem[66] = enc_i(12'd8, 5'd0, 3'b010, 5'd5, 7'b0000011);
    mem[67] = enc_sw(5'd5, 5'd0, 12'd12);
    release_rst();
    wait_halt(ok);
    total++; if (!ok) begin bad++; $display("FAIL mem_halt_timeout got=0 exp=1"); end
    total++; if (st_cnt !== 2) begin bad++; $display("FAIL mem_stores got=%0d exp=2", st_cnt); end
    total++; if (st_addr[0] !== 32'h8) begin bad++; $display("FAIL mem_st_addr got=%h exp=8", st_addr[0]); end
    total++; if (st_data[0] !== 32'h2) begin bad++; $display("FAIL mem_st_data got=%h exp=2", st_data[0]); end
    total++; if (mem[3] !== 32'h2) begin bad++; $display("FAIL mem_x5 got=%h exp=2", mem[3]); end
    total++; if (ret_cyc[1] - ret_cyc[0] !== 4) begin bad++; $display("FAIL mem_sw_lat got=%0d exp=4", ret_cyc[1] - ret_cyc[0]); end
    total++; if (ret_cyc[2] - ret_cyc[1] !== 5) begin bad++; $display("FAIL mem_lw_lat got=%0d exp=5", ret_cyc[2] - ret_cyc[1]); end
  endtask

  task automatic test_ctrl();
    begin_test(32'hFFFF_FFF0, 0);
    mem[64] = addi(5'd1, 5'd0, 12'd1);
    mem[65] = addi(5'd2, 5'd0, 12'd2);
    mem[66] = enc_b(3'b001, 5'd1, 5'd2, 13'd8);
    mem[67] = addi(5'd7, 5'd0, 12'd99);
    mem[68] = enc_j(5'd1, 21'd20);
    mem[69] = enc_sw(5'd6, 5'd0, 12'd20);
    mem[70] = enc_sw(5'd1, 5'd0, 12'd16);
    mem[71] = enc_sw(5'd7, 5'd0, 12'd24);
    mem[73] = addi(5'd6, 5'd0, 12'd33);
    mem[74] = enc_i(12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111);
    release_rst();
    wait_halt(ok);
    total++; if (!ok) begin bad++; $display("FAIL ctrl_halt_timeout got=0 exp=1"); end
    total++; if (ret_cnt !== 9) begin bad++; $display("FAIL ctrl_retires got=%0d exp=9", ret_cnt); end
    total++; if (ret_cyc[2] - ret_cyc[1] !== 3) begin bad++; $display("FAIL ctrl_bne_lat got=%0d exp=3", ret_cyc[2] - ret_cyc[1]); end
    total++; if (ret_cyc[3] - ret_cyc[2] !== 4) begin bad++; $display("FAIL ctrl_jal_lat got=%0d exp=4", ret_cyc[3] - ret_cyc[2]); end
    total++; if (fe_addr[3] !== 32'h110) begin bad++; $display("FAIL ctrl_bne_tgt got=%h exp=110", fe_addr[3]); end
    total++; if (fe_addr[4] !== 32'h124) begin bad++; $display("FAIL ctrl_jal_tgt got=%h exp=124", fe_addr[4]); end
    total++; if (fe_addr[6] !== 32'h114) begin bad++; $display("FAIL ctrl_jalr_tgt got=%h exp=114", fe_addr[6]); end
    total++; if (mem[4] !== 32'h114) begin bad++; $display("FAIL ctrl_link got=%h exp=114", mem[4]); end
    total++; if (mem[5] !== 32'd33) begin bad++; $display("FAIL ctrl_x6 got=%h exp=21", mem[5]); end
    total++; if (mem[6] !== 32'h0) begin bad++; $display("FAIL ctrl_skip got=%h exp=0", mem[6]); end
  endtask

  task automatic test_faults();
    begin_test(32'hFFFF_FFF0, 0);
    mem[1]  = 32'h1234_5678;
    mem[64] = addi(5'd1, 5'd0, 12'd7);
    mem[65] = enc_i(12'd6, 5'd0, 3'b010, 5'd1, 7'b0000011);
    release_rst();
    wait_halt(ok);
    repeat (3) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL lw_mis_halt got=0 exp=1"); end
    total++; if (req_done !== 2) begin bad++; $display("FAIL lw_mis_reqs got=%0d exp=2", req_done); end
    total++; if (ret_cnt !== 1) begin bad++; $display("FAIL lw_mis_retires got=%0d exp=1", ret_cnt); end
    total++; if (pc_out !== 32'h104) begin bad++; $display("FAIL lw_mis_pc got=%h exp=104", pc_out); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL halt_req got=%b exp=0", mem_req); end

    begin_test(32'hFFFF_FFF0, 0);
    mem[64] = enc_b(3'b000, 5'd0, 5'd0, 13'd6);
    release_rst();
    wait_halt(ok);
    total++; if (!ok) begin bad++; $display("FAIL br_mis_halt got=0 exp=1"); end
    total++; if (ret_cnt !== 0) begin bad++; $display("FAIL br_mis_retires got=%0d exp=0", ret_cnt); end
    total++; if (pc_out !== 32'h100) begin bad++; $display("FAIL br_mis_pc got=%h exp=100", pc_out); end

    begin_test(32'hFFFF_FFF0, 0);
    mem[64] = 32'h0000_007F;
    release_rst();
    wait_halt(ok);
    total++; if (!ok) begin bad++; $display("FAIL illegal_halt got=0 exp=1"); end
    total++; if (ret_cnt !== 0) begin bad++; $display("FAIL illegal_retires got=%0d exp=0", ret_cnt); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_clears_halt got=%b exp=0", halted); end

    release_rst();
    repeat (40) @(negedge clk);
    total++; if (n_halted !== 1'b0) begin bad++; $display("FAIL nop_halted got=%b exp=0", n_halted); end
    total++; if (n_st_cnt !== 1) begin bad++; $display("FAIL nop_stores got=%0d exp=1", n_st_cnt); end
    total++; if (n_st_addr !== 32'h4) begin bad++; $display("FAIL nop_st_addr got=%h exp=4", n_st_addr); end
    total++; if (n_st_data !== 32'h5) begin bad++; $display("FAIL nop_st_data got=%h exp=5", n_st_data); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_wait();
    test_mem();
    test_ctrl();
    test_faults();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
